// File: rtl/std_nbdcache_vd_init_ctrl.sv
// Valid/dirty SRAM front end for the non-blocking D-cache.
// Sweeps every word to InitValue after reset or on request,
// then forwards client accesses and generates a read strobe.
//
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   init_req_i         request a full re-invalidation sweep
//   init_busy_o        sweep pending or running
//   init_done_o        one-cycle pulse at sweep end
//   req_i/gnt_o        client handshake (no buffering)
//   we_i, addr_i,
//   wdata_i, be_i      client access
//   rvalid_o, rdata_o  read response (one cycle after grant)
//   sram_*             single-port SRAM, read latency 1
module std_nbdcache_vd_init_ctrl #(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 128,
  parameter int ByteWidth = 8,
  parameter logic [DataWidth-1:0] InitValue = '0,
  localparam int AddrWidth =
    (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int BeWidth =
    (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 init_req_i,
  output logic                 init_busy_o,
  output logic                 init_done_o,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  typedef enum logic [1:0] {
    HOLD,
    SWEEP,
    READY
  } state_t;

  localparam logic [AddrWidth-1:0] LastAddr =
    AddrWidth'(NumWords - 1);

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 rvalid_q, rvalid_d;
  logic                 last;

  assign last = (cnt_q == LastAddr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    rvalid_d     = 1'b0;
    init_busy_o  = 1'b1;
    gnt_o        = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    unique case (state_q)
      HOLD: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
      SWEEP: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = cnt_q;
        sram_wdata_o = InitValue;
        sram_be_o    = '1;
        if (last) begin
          state_d = READY;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AddrWidth'(1);
        end
      end
      READY: begin
        // The request in the init cycle is still served.
        init_busy_o = init_req_i;
        gnt_o       = req_i;
        rvalid_d    = req_i & ~we_i;
        if (req_i) begin
          sram_req_o   = 1'b1;
          sram_we_o    = we_i;
          sram_addr_o  = addr_i;
          sram_wdata_o = wdata_i;
          sram_be_o    = be_i;
        end
        if (init_req_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_done_o = done_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rvalid_q ? sram_rdata_i : '0;

endmodule

// File: doc/std_nbdcache_vd_init_ctrl.md
Name: std_nbdcache_vd_init_ctrl

Overview:
- Front-end controller directly upstream of the non-blocking D-cache valid/dirty SRAM macro.
- After reset, or on request, it sweeps every valid/dirty word to the invalid/clean value. The cache tag controller cannot trust the SRAM contents until this sweep completes.
- Outside a sweep it forwards cache-controller requests to the single-port SRAM. It also generates a read-valid strobe, because the macro itself gives none.

Parameters:
- NumWords, 1024, SRAM depth in words.
- DataWidth, 128, SRAM word width in bits.
- ByteWidth, 8, bits per byte-enable lane.
- InitValue, '0 (DataWidth bits), pattern written during a sweep.
- AddrWidth, derived = NumWords>1 ? $clog2(NumWords) : 1, do not override.
- BeWidth, derived = ceil(DataWidth/ByteWidth), do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- init_req_i  in  1  start a full re-invalidation sweep (level, sampled)
- init_busy_o  out  1  sweep pending or in progress
- init_done_o  out  1  one-cycle pulse when a sweep completes
- req_i  in  1  client request
- gnt_o  out  1  client grant
- we_i  in  1  client write enable
- addr_i  in  AddrWidth  client address
- wdata_i  in  DataWidth  client write data
- be_i  in  BeWidth  client byte enable
- rvalid_o  out  1  read data valid
- rdata_o  out  DataWidth  read data
- sram_req_o  out  1  SRAM request
- sram_we_o  out  1  SRAM write enable
- sram_addr_o  out  AddrWidth  SRAM address
- sram_wdata_o  out  DataWidth  SRAM write data
- sram_be_o  out  BeWidth  SRAM byte enable
- sram_rdata_i  in  DataWidth  SRAM read data (latency 1)

Behaviour:
- One clock. Reset is asynchronous and active-high; clock port clk_i, reset port rst_i.
- States: HOLD (reset state), SWEEP, READY. Sweep counter cnt is AddrWidth bits and resets to 0.
- Output reset values: init_busy_o=1, init_done_o=0, gnt_o=0, rvalid_o=0, sram_req_o=0, sram_we_o=0, sram_addr_o=0, sram_wdata_o=0, sram_be_o=0, rdata_o=0.
- HOLD:
  - No SRAM access; init_busy_o=1.
  - Moves unconditionally to SWEEP on the first clock edge after rst_i is released.
- SWEEP:
  - Every cycle: sram_req_o=1, sram_we_o=1, sram_addr_o=cnt, sram_wdata_o=InitValue, sram_be_o=all ones. cnt then increments.
  - gnt_o=0 regardless of req_i; init_busy_o=1.
  - When cnt==NumWords-1, that write is the last one: next state is READY, cnt goes to 0, init_done_o=1 for exactly the following cycle.
  - A sweep therefore takes exactly NumWords cycles. With NumWords=1 it is one cycle.
  - init_req_i is ignored in SWEEP; the sweep does not restart.
- READY:
  - init_busy_o=0.
  - gnt_o=req_i, combinationally.
  - sram_* outputs mirror the client inputs combinationally: sram_req_o=req_i, sram_we_o=we_i, and so on.
  - When req_i=0, sram_we_o/addr/wdata/be are driven 0.
- init_req_i in READY:
  - The current cycle's client request is still granted and executed.
  - Next state is SWEEP, with cnt=0. init_busy_o rises combinationally in that same cycle.
- Read strobe:
  - rvalid_o is registered: 1 the cycle after a granted request with we_i=0, otherwise 0.
  - rdata_o = sram_rdata_i when rvalid_o=1, else 0.
  - A read granted in the last READY cycle before a sweep still returns rvalid_o in the first SWEEP cycle.
  - Writes and sweep writes never raise rvalid_o.
- Reset asserted mid-sweep or mid-read: immediately returns to HOLD with all reset values. Any pending rvalid_o is dropped and cnt returns to 0.
- Only one SRAM access per cycle; no internal buffering of client requests (the client retries while gnt_o=0).

Test Plan (NumWords=8, DataWidth=16, ByteWidth=8 unless stated):
- Reset release -> 1 HOLD cycle, then 8 consecutive sram writes to addr 0..7 with wdata=0x0000 and be=2'b11. init_done_o pulses on cycle 10 after release. init_busy_o falls together with the pulse.
- req_i held high from reset -> gnt_o=0 through the sweep; first grant in the cycle init_done_o=1. A write of 0xA5A5 to addr 3 followed by a read of addr 3 -> rvalid_o=1 one cycle after the read grant, with rdata_o=0xA5A5.
- In READY, init_req_i and a read of addr 5 in the same cycle -> read is granted. Next cycle: rvalid_o=1 and sram_addr_o=0 (sweep begins). The sweep takes 8 cycles.
- init_req_i pulsed at sweep cycle 4 -> no restart; init_done_o still pulses exactly once, 8 cycles after the sweep started.
- rst_i asserted at sweep cycle 5 and released 2 cycles later -> outputs at reset values immediately; the new sweep restarts at addr 0 and covers all 8 addresses.
- NumWords=1 -> sweep is a single write to addr 0, followed by an init_done_o pulse on the next cycle.
